rom_burst_ctrl: RTL and testbench

//  Parametrised read-only memory controller with valid/ready request and response handshakes.

---
 rtl/rom_burst_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rom_burst_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_ctrl.sv
// ============================================================================
// Module   : rom_burst_ctrl
// Purpose  : Read-only lookup memory with valid/ready request and response
//            handshakes, single/burst reads and wrap-around addressing.
//            Optional: ROM_BURST_CTRL_PARITY_EN adds a registered rsp_parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ONEHOT = 1,
    parameter int LEN_W  = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 req_valid,
    output logic                                                 req_ready,
    input  logic [((ONEHOT != 0) ? DEPTH : $clog2(DEPTH))-1:0]  req_addr,
    input  logic [LEN_W-1:0]                                     req_len,
    output logic                                                 rsp_valid,
    input  logic                                                 rsp_ready,
    output logic [DATA_W-1:0]                                    rsp_data,
    output logic                                                 rsp_last,
    output logic                                                 rsp_err,
    output logic                                                 busy
`ifdef ROM_BURST_CTRL_PARITY_EN
    ,
    output logic                                                 rsp_parity
`endif
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [LEN_W-1:0]  r_cnt;

    logic [IW-1:0]     w_addr_idx;
    logic              w_addr_ok;
    logic [IW-1:0]     w_next_idx;
    logic [DATA_W-1:0] w_load_data;
    logic              w_accept;
    logic              w_adv;

    // Entry i is nibble (i+1)%16 repeated across the word, low bits first.
    function automatic logic [DATA_W-1:0] rom_word(input logic [IW-1:0] idx);
        logic [31:0]       nib;
        logic [DATA_W-1:0] w;
        nib = 32'(idx) + 32'd1;
        w   = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w[b] = nib[b % 4];
        end
        return w;
    endfunction

    generate
        if (ONEHOT != 0) begin : g_onehot
            always_comb begin
                w_addr_idx = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (req_addr[i]) begin
                        w_addr_idx = IW'(i);
                    end
                end
            end
            assign w_addr_ok = $onehot(req_addr);
        end else begin : g_binary
            assign w_addr_idx = req_addr;
            assign w_addr_ok  = ({1'b0, req_addr} < (IW+1)'(DEPTH));
        end
    endgenerate

    assign w_accept   = req_valid && req_ready;
    assign w_adv      = rsp_valid && rsp_ready;
    assign w_next_idx = (r_idx == IW'(DEPTH - 1)) ? '0 : (r_idx + 1'b1);

    always_comb begin
        w_load_data = rom_word(w_next_idx);
        if (r_state == S_IDLE) begin
            w_load_data = w_addr_ok ? rom_word(w_addr_idx) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_BURST;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= w_load_data;
                        r_idx     <= w_addr_idx;
                        if (w_addr_ok) begin
                            r_cnt    <= req_len;
                            rsp_last <= (req_len == '0);
                            rsp_err  <= 1'b0;
                        end else begin
                            // Bad address collapses to a single error beat.
                            r_cnt    <= '0;
                            rsp_last <= 1'b1;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (w_adv) begin
                        if (r_cnt == '0) begin
                            r_state   <= S_IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            rsp_valid <= 1'b0;
                            rsp_last  <= 1'b0;
                            rsp_err   <= 1'b0;
                        end else begin
                            r_idx    <= w_next_idx;
                            r_cnt    <= r_cnt - 1'b1;
                            rsp_last <= (r_cnt == LEN_W'(1));
                            rsp_data <= w_load_data;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROM_BURST_CTRL_PARITY_EN
    logic w_load;
    assign w_load = w_accept || (w_adv && (r_cnt != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_parity <= 1'b0;
        end else if (w_load) begin
            rsp_parity <= ^w_load_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_burst_ctrl.sv
// ============================================================================
// Module   : tb_rom_burst_ctrl
// Purpose  : Directed, table-driven bench for rom_burst_ctrl (one-hot and
//            binary instances, plus a 12-bit parity instance when enabled).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_burst_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // One-hot default instance
    logic       oh_req_valid, oh_req_ready, oh_rsp_valid, oh_rsp_ready;
    logic [7:0] oh_addr, oh_data;
    logic [3:0] oh_len;
    logic       oh_last, oh_err, oh_busy;

    // Binary-address instance
    logic       bn_req_valid, bn_req_ready, bn_rsp_valid, bn_rsp_ready;
    logic [2:0] bn_addr;
    logic [7:0] bn_data;
    logic [3:0] bn_len;
    logic       bn_last, bn_err, bn_busy;

`ifdef ROM_BURST_CTRL_PARITY_EN
    logic        oh_par, bn_par;
    logic        p_req_valid, p_req_ready, p_rsp_valid, p_rsp_ready;
    logic [2:0]  p_addr;
    logic [3:0]  p_len;
    logic [11:0] p_data;
    logic        p_last, p_err, p_busy, p_par;
`endif

    rom_burst_ctrl u_oh (
        .clk(clk), .rst(rst),
        .req_valid(oh_req_valid), .req_ready(oh_req_ready),
        .req_addr(oh_addr), .req_len(oh_len),
        .rsp_valid(oh_rsp_valid), .rsp_ready(oh_rsp_ready),
        .rsp_data(oh_data), .rsp_last(oh_last), .rsp_err(oh_err),
        .busy(oh_busy)
`ifdef ROM_BURST_CTRL_PARITY_EN
        , .rsp_parity(oh_par)
`endif
    );

    rom_burst_ctrl #(.ONEHOT(0)) u_bn (
        .clk(clk), .rst(rst),
        .req_valid(bn_req_valid), .req_ready(bn_req_ready),
        .req_addr(bn_addr), .req_len(bn_len),
        .rsp_valid(bn_rsp_valid), .rsp_ready(bn_rsp_ready),
        .rsp_data(bn_data), .rsp_last(bn_last), .rsp_err(bn_err),
        .busy(bn_busy)
`ifdef ROM_BURST_CTRL_PARITY_EN
        , .rsp_parity(bn_par)
`endif
    );

`ifdef ROM_BURST_CTRL_PARITY_EN
    rom_burst_ctrl #(.DATA_W(12), .ONEHOT(0)) u_par (
        .clk(clk), .rst(rst),
        .req_valid(p_req_valid), .req_ready(p_req_ready),
        .req_addr(p_addr), .req_len(p_len),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready),
        .rsp_data(p_data), .rsp_last(p_last), .rsp_err(p_err),
        .busy(p_busy), .rsp_parity(p_par)
    );
`endif

    typedef struct {
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_oh_ready();
        int k = 0;
        while (!oh_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!oh_req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL oh_ready_timeout: req_ready still 0 after %0d cycles", k);
        end
    endtask

    // Called on a negedge; returns on the negedge after the controller idles.
    task automatic oh_single(input logic [7:0] a, input logic [3:0] l,
                             input logic [7:0] ed, input logic ee);
        wait_oh_ready();
        oh_req_valid = 1'b1;
        oh_addr      = a;
        oh_len       = l;
        oh_rsp_ready = 1'b1;
        @(negedge clk);
        oh_req_valid = 1'b0;
        chk("single_valid", 32'(oh_rsp_valid), 32'd1);
        chk("single_data",  32'(oh_data),      32'(ed));
        chk("single_last",  32'(oh_last),      32'd1);
        chk("single_err",   32'(oh_err),       32'(ee));
        chk("single_rdy",   32'(oh_req_ready), 32'd0);
        chk("single_busy",  32'(oh_busy),      32'd1);
        @(negedge clk);
        chk("single_done_valid", 32'(oh_rsp_valid), 32'd0);
        chk("single_done_rdy",   32'(oh_req_ready), 32'd1);
        chk("single_done_busy",  32'(oh_busy),      32'd0);
    endtask

    logic [7:0] exp_b[4];

    initial begin
        vecs[0]  = '{8'h01, 4'd0, 8'h11, 1'b0};
        vecs[1]  = '{8'h02, 4'd0, 8'h22, 1'b0};
        vecs[2]  = '{8'h04, 4'd0, 8'h33, 1'b0};
        vecs[3]  = '{8'h08, 4'd0, 8'h44, 1'b0};
        vecs[4]  = '{8'h10, 4'd0, 8'h55, 1'b0};
        vecs[5]  = '{8'h20, 4'd0, 8'h66, 1'b0};
        vecs[6]  = '{8'h40, 4'd0, 8'h77, 1'b0};
        vecs[7]  = '{8'h80, 4'd0, 8'h88, 1'b0};
        vecs[8]  = '{8'h03, 4'd5, 8'h00, 1'b1};
        vecs[9]  = '{8'h00, 4'd0, 8'h00, 1'b1};
        vecs[10] = '{8'hFF, 4'd2, 8'h00, 1'b1};

        oh_req_valid = 0; oh_addr = 0; oh_len = 0; oh_rsp_ready = 0;
        bn_req_valid = 0; bn_addr = 0; bn_len = 0; bn_rsp_ready = 0;
`ifdef ROM_BURST_CTRL_PARITY_EN
        p_req_valid = 0; p_addr = 0; p_len = 0; p_rsp_ready = 0;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(oh_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(oh_rsp_valid), 32'd0);
        chk("rst_last",      32'(oh_last),      32'd0);
        chk("rst_err",       32'(oh_err),       32'd0);
        chk("rst_busy",      32'(oh_busy),      32'd0);
        chk("rst_data",      32'(oh_data),      32'd0);
        chk("rst_bn_ready",  32'(bn_req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single reads and illegal one-hot addresses
        for (int i = 0; i < 11; i++) begin
            oh_single(vecs[i].addr, vecs[i].len, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Binary burst with wrap: addr 6, len 3
        exp_b[0] = 8'h77; exp_b[1] = 8'h88; exp_b[2] = 8'h11; exp_b[3] = 8'h22;
        bn_req_valid = 1'b1; bn_addr = 3'd6; bn_len = 4'd3; bn_rsp_ready = 1'b1;
        @(negedge clk);
        bn_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", 32'(bn_rsp_valid), 32'd1);
            chk("wrap_data",  32'(bn_data),      32'(exp_b[i]));
            chk("wrap_last",  32'(bn_last),      (i == 3) ? 32'd1 : 32'd0);
            chk("wrap_err",   32'(bn_err),       32'd0);
            @(negedge clk);
        end
        chk("wrap_done_valid", 32'(bn_rsp_valid), 32'd0);
        chk("wrap_done_ready", 32'(bn_req_ready), 32'd1);

        // Backpressure on the 2nd beat; a competing request must be ignored
        wait_oh_ready();
        oh_req_valid = 1'b1; oh_addr = 8'h01; oh_len = 4'd2; oh_rsp_ready = 1'b1;
        @(negedge clk);
        oh_req_valid = 1'b0;
        chk("bp_beat0",      32'(oh_data), 32'h11);
        chk("bp_beat0_last", 32'(oh_last), 32'd0);
        @(negedge clk);
        chk("bp_beat1", 32'(oh_data), 32'h22);
        oh_rsp_ready = 1'b0;
        oh_req_valid = 1'b1; oh_addr = 8'h80; oh_len = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(oh_rsp_valid), 32'd1);
            chk("bp_hold_data",  32'(oh_data),      32'h22);
            chk("bp_hold_last",  32'(oh_last),      32'd0);
        end
        oh_req_valid = 1'b0;
        oh_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_beat2",      32'(oh_data), 32'h33);
        chk("bp_beat2_last", 32'(oh_last), 32'd1);
        @(negedge clk);
        chk("bp_done_valid", 32'(oh_rsp_valid), 32'd0);
        chk("bp_done_ready", 32'(oh_req_ready), 32'd1);

        // Asynchronous reset in the middle of an 8-beat burst
        oh_req_valid = 1'b1; oh_addr = 8'h01; oh_len = 4'd7; oh_rsp_ready = 1'b1;
        @(negedge clk);
        oh_req_valid = 1'b0;
        chk("mid_beat0", 32'(oh_data), 32'h11);
        @(negedge clk);
        chk("mid_beat1", 32'(oh_data), 32'h22);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(oh_rsp_valid), 32'd0);
        chk("mid_rst_busy",  32'(oh_busy),      32'd0);
        chk("mid_rst_ready", 32'(oh_req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(oh_req_ready), 32'd1);
        chk("post_rst_valid", 32'(oh_rsp_valid), 32'd0);
        oh_single(8'h10, 4'd0, 8'h55, 1'b0);

`ifdef ROM_BURST_CTRL_PARITY_EN
        p_req_valid = 1'b1; p_addr = 3'd0; p_len = 4'd0; p_rsp_ready = 1'b1;
        @(negedge clk);
        p_req_valid = 1'b0;
        chk("par_data0", 32'(p_data), 32'h111);
        chk("par_bit0",  32'(p_par),  32'd1);
        @(negedge clk);
        p_req_valid = 1'b1; p_addr = 3'd2;
        @(negedge clk);
        p_req_valid = 1'b0;
        chk("par_data2", 32'(p_data), 32'h333);
        chk("par_bit2",  32'(p_par),  32'd0);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
